// File: rtl/ov7670_pixel_capture.sv
// OV7670 write-side capture: registers the camera bus, pairs RGB444 bytes into 12-bit pixels
// and drives raster-order writes into frame_buffer, one frame per VSYNC low period.
module ov7670_pixel_capture #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned DEPTH    = H_ACTIVE * V_ACTIVE,
  parameter int unsigned ADDR_W   = $clog2(DEPTH),
  parameter int unsigned PIX_W    = 12
) (
  input  logic              wr_clk,
  input  logic              rst_n,
  input  logic              capture_en,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_d,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  data_out,
  output logic              frame_done,
  output logic              overflow,
  output logic              short_frame
);

  typedef enum logic [1:0] {StSync, StVblank, StActive, StSkip} state_e;

  localparam logic [ADDR_W:0]   DepthCnt = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  state_e              state_q, state_d;
  logic                vsync_d1, vsync_d2, href_d1, capen_d1;
  logic [7:0]          cam_d_d1;
  logic                byte_sel_q, byte_sel_d;
  logic [3:0]          r_nib_q, r_nib_d;
  logic [ADDR_W:0]     pix_cnt_q, pix_cnt_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [PIX_W-1:0]    data_q, data_d;
  logic                wr_en_q, wr_en_d;
  logic                frame_done_q, frame_done_d;
  logic                overflow_q, overflow_d;
  logic                short_q, short_d;
  logic                vs_rise, vs_fall;

  assign vs_rise = vsync_d1 & ~vsync_d2;
  assign vs_fall = ~vsync_d1 & vsync_d2;

  always_comb begin
    state_d      = state_q;
    byte_sel_d   = byte_sel_q;
    r_nib_d      = r_nib_q;
    pix_cnt_d    = pix_cnt_q;
    data_d       = data_q;
    wr_en_d      = 1'b0;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q;
    short_d      = short_q;
    // Address trails the count by one cycle and saturates once the frame is full.
    wr_addr_d    = (pix_cnt_q < DepthCnt) ? pix_cnt_q[ADDR_W-1:0] : LastAddr;
    unique case (state_q)
      StSync: begin
        if (vsync_d1) state_d = StVblank;
      end
      StVblank: begin
        if (vs_fall) begin
          pix_cnt_d  = '0;
          wr_addr_d  = '0;
          overflow_d = 1'b0;
          short_d    = 1'b0;
          byte_sel_d = 1'b0;
          state_d    = capen_d1 ? StActive : StSkip;
        end
      end
      StActive: begin
        if (vs_rise) begin
          frame_done_d = 1'b1;
          short_d      = (pix_cnt_q < DepthCnt);
          byte_sel_d   = 1'b0;
          state_d      = StVblank;
        end else if (href_d1 && !vsync_d1) begin
          byte_sel_d = ~byte_sel_q;
          if (!byte_sel_q) begin
            r_nib_d = cam_d_d1[3:0];
          end else if (pix_cnt_q < DepthCnt) begin
            wr_en_d   = 1'b1;
            data_d    = {r_nib_q, cam_d_d1};
            pix_cnt_d = pix_cnt_q + 1'b1;
          end else begin
            overflow_d = 1'b1;
          end
        end else begin
          byte_sel_d = 1'b0;
        end
      end
      StSkip: begin
        if (vs_rise) state_d = StVblank;
      end
      default: state_d = StSync;
    endcase
  end

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d1     <= 1'b0;
      vsync_d2     <= 1'b0;
      href_d1      <= 1'b0;
      capen_d1     <= 1'b0;
      cam_d_d1     <= '0;
      state_q      <= StSync;
      byte_sel_q   <= 1'b0;
      r_nib_q      <= '0;
      pix_cnt_q    <= '0;
      wr_addr_q    <= '0;
      data_q       <= '0;
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      short_q      <= 1'b0;
    end else begin
      vsync_d1     <= cam_vsync;
      vsync_d2     <= vsync_d1;
      href_d1      <= cam_href;
      capen_d1     <= capture_en;
      cam_d_d1     <= cam_d;
      state_q      <= state_d;
      byte_sel_q   <= byte_sel_d;
      r_nib_q      <= r_nib_d;
      pix_cnt_q    <= pix_cnt_d;
      wr_addr_q    <= wr_addr_d;
      data_q       <= data_d;
      wr_en_q      <= wr_en_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
      short_q      <= short_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign data_out    = data_q;
  assign frame_done  = frame_done_q;
  assign overflow    = overflow_q;
  assign short_frame = short_q;

endmodule

// File: tb/tb_ov7670_pixel_capture.sv
// Scoreboard bench for ov7670_pixel_capture on a small 4x3 frame; expected writes are
// queued as bytes are driven and retired by a monitor watching wr_en.
module tb_ov7670_pixel_capture;

  localparam int unsigned H      = 4;
  localparam int unsigned V      = 3;
  localparam int unsigned DEPTH  = H * V;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned PIX_W  = 12;

  logic              wr_clk;
  logic              rst_n;
  logic              capture_en;
  logic              cam_vsync;
  logic              cam_href;
  logic [7:0]        cam_d;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  data_out;
  logic              frame_done;
  logic              overflow;
  logic              short_frame;

  ov7670_pixel_capture #(
    .H_ACTIVE(H),
    .V_ACTIVE(V),
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .PIX_W   (PIX_W)
  ) dut (
    .wr_clk     (wr_clk),
    .rst_n      (rst_n),
    .capture_en (capture_en),
    .cam_vsync  (cam_vsync),
    .cam_href   (cam_href),
    .cam_d      (cam_d),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .data_out   (data_out),
    .frame_done (frame_done),
    .overflow   (overflow),
    .short_frame(short_frame)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  int n_vec;
  int n_err;
  int fd_cnt;
  logic [ADDR_W+PIX_W-1:0] exp_q[$];

  // Reference model state
  bit          m_cap;
  bit          m_sel;
  bit          m_ovf;
  logic [3:0]  m_nib;
  int unsigned m_cnt;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge wr_clk) begin
    logic [ADDR_W+PIX_W-1:0] e;
    if (frame_done) fd_cnt++;
    if (wr_en) begin
      if (exp_q.size() == 0) begin
        check_val("spurious_write", 32'(wr_addr), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check_val("wr_data", 32'(data_out), 32'(e[PIX_W-1:0]));
        check_val("wr_addr", 32'(wr_addr), 32'(e[ADDR_W+PIX_W-1:PIX_W]));
      end
    end
  end

  task automatic tick(input logic vs, input logic hr, input logic [7:0] d);
    @(negedge wr_clk);
    cam_vsync = vs;
    cam_href  = hr;
    cam_d     = d;
  endtask

  task automatic send_byte(input logic [7:0] b);
    tick(1'b0, 1'b1, b);
    if (m_cap) begin
      if (!m_sel) begin
        m_nib = b[3:0];
        m_sel = 1'b1;
      end else begin
        m_sel = 1'b0;
        if (m_cnt < DEPTH) begin
          exp_q.push_back({ADDR_W'(m_cnt), m_nib, b});
          m_cnt++;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  endtask

  task automatic end_line();
    repeat (3) tick(1'b0, 1'b0, 8'h00);
    m_sel = 1'b0;
  endtask

  task automatic send_pixels(input int unsigned n);
    repeat (n) begin
      send_byte(8'($urandom));
      send_byte(8'($urandom));
    end
    end_line();
  endtask

  // Ends the current frame with a VSYNC pulse (href chatter during blanking) and opens the next.
  task automatic frame_boundary(input logic next_cap);
    int fd0;
    fd0 = fd_cnt;
    tick(1'b1, 1'b1, 8'hC3);
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b1, 8'h5A);
    tick(1'b1, 1'b1, 8'hA5);
    tick(1'b1, 1'b0, 8'h00);
    check_val("frame_done_pulses", 32'(fd_cnt - fd0), 32'(m_cap));
    check_val("short_frame_end", 32'(short_frame), 32'(m_cap && (m_cnt < DEPTH)));
    check_val("overflow_end", 32'(overflow), 32'(m_ovf));
    check_val("pending_writes", 32'(exp_q.size()), 32'd0);
    if (m_ovf) check_val("addr_hold", 32'(wr_addr), 32'(DEPTH - 1));
    capture_en = next_cap;
    tick(1'b1, 1'b0, 8'h00);
    repeat (4) tick(1'b0, 1'b0, 8'h00);
    m_cap = next_cap;
    m_cnt = 0;
    m_sel = 1'b0;
    m_ovf = 1'b0;
    check_val("overflow_cleared", 32'(overflow), 32'd0);
    check_val("short_cleared", 32'(short_frame), 32'd0);
  endtask

  initial begin
    n_vec = 0; n_err = 0; fd_cnt = 0;
    m_cap = 1'b0; m_sel = 1'b0; m_ovf = 1'b0; m_nib = '0; m_cnt = 0;
    rst_n = 1'b0; capture_en = 1'b0;
    cam_vsync = 1'b0; cam_href = 1'b0; cam_d = 8'h00;
    #12;
    check_val("rst_wr_en", 32'(wr_en), 32'd0);
    check_val("rst_wr_addr", 32'(wr_addr), 32'd0);
    check_val("rst_data_out", 32'(data_out), 32'd0);
    check_val("rst_frame_done", 32'(frame_done), 32'd0);
    check_val("rst_overflow", 32'(overflow), 32'd0);
    check_val("rst_short", 32'(short_frame), 32'd0);
    @(negedge wr_clk);
    rst_n = 1'b1;

    // Mid-frame data after reset must not be captured
    capture_en = 1'b1;
    send_pixels(3);
    frame_boundary(1'b1);

    // Full frame
    repeat (V) send_pixels(H);
    frame_boundary(1'b1);

    // Reset mid-line with a byte pending; rest of the frame is dropped
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    @(negedge wr_clk);
    #1 rst_n = 1'b0;
    m_cap = 1'b0; m_sel = 1'b0; m_cnt = 0; m_ovf = 1'b0;
    #3 check_val("midreset_wr_en", 32'(wr_en), 32'd0);
    @(negedge wr_clk);
    rst_n = 1'b1;
    send_byte(8'h9A);
    send_pixels(4);
    frame_boundary(1'b1);

    // Latency and pairing, odd byte dropped at line end, pending byte dropped at vsync rise
    send_byte(8'hA5);
    send_byte(8'h3C);
    @(posedge wr_clk);
    @(negedge wr_clk);
    cam_href = 1'b0;
    @(posedge wr_clk);
    #1;
    check_val("lat_wr_en", 32'(wr_en), 32'd1);
    check_val("lat_data", 32'(data_out), 32'h53C);
    check_val("lat_addr", 32'(wr_addr), 32'd0);
    @(posedge wr_clk);
    #1;
    check_val("lat_one_cycle", 32'(wr_en), 32'd0);
    check_val("data_hold", 32'(data_out), 32'h53C);
    end_line();
    send_byte(8'h01);
    send_byte(8'h23);
    send_byte(8'h45);
    end_line();
    send_byte(8'h06);
    send_byte(8'h78);
    end_line();
    send_byte(8'h9B);
    frame_boundary(1'b0);

    // Skipped frame: capture_en raised mid-frame has no effect
    send_pixels(2);
    capture_en = 1'b1;
    repeat (V) send_pixels(H);
    frame_boundary(1'b1);

    // Normal frame following the skipped one
    repeat (V) send_pixels(H);
    frame_boundary(1'b1);

    // Overlong frame
    repeat (V) send_pixels(H);
    send_pixels(1);
    frame_boundary(1'b1);

    // Short frame, then a frame that must restart at address 0
    send_pixels(H);
    frame_boundary(1'b1);
    send_pixels(2);
    frame_boundary(1'b0);

    repeat (5) tick(1'b0, 1'b0, 8'h00);
    check_val("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
